// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round datapath reused for all ten rounds,
// round keys expanded on the fly alongside the state.
module aes_encrypt_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic         busy,
  output logic [127:0] out,
  output logic         out_valid
);

  // state | meaning
  // IDLE  | waiting for start; out holds the last result
  // BUSY  | rounds 1..NR in progress, rnd = round applied on the next edge
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte n of the block lives at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk,
                                              input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  fsm_t         fsm_state, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] rk_reg, rk_next;
  logic [3:0]   rnd, rnd_next;
  logic [127:0] out_next;
  logic         valid_next;
  logic [127:0] round_key;
  logic [127:0] shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state <= IDLE;
      state_reg <= '0;
      rk_reg    <= '0;
      rnd       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm_state <= fsm_next;
      state_reg <= state_next;
      rk_reg    <= rk_next;
      rnd       <= rnd_next;
      out       <= out_next;
      out_valid <= valid_next;
    end
  end

  assign round_key = key_expand(rk_reg, rcon(rnd));
  assign shifted   = sub_shift(state_reg);
  assign busy      = (fsm_state == BUSY);

  always_comb begin
    fsm_next   = fsm_state;
    state_next = state_reg;
    rk_next    = rk_reg;
    rnd_next   = rnd;
    out_next   = out;
    valid_next = 1'b0;
    case (fsm_state)
      IDLE: begin
        if (start) begin
          state_next = in ^ key;
          rk_next    = key;
          rnd_next   = 4'd1;
          fsm_next   = BUSY;
        end
      end
      BUSY: begin
        if (rnd == 4'd0 || rnd > LAST) begin
          fsm_next = IDLE;
          rnd_next = 4'd0;
        end else if (rnd == LAST) begin
          // Final round: no MixColumns.
          out_next   = shifted ^ round_key;
          valid_next = 1'b1;
          rnd_next   = 4'd0;
          fsm_next   = IDLE;
        end else begin
          state_next = mix_columns(shifted) ^ round_key;
          rk_next    = round_key;
          rnd_next   = rnd + 4'd1;
        end
      end
      default: begin
        fsm_next = IDLE;
        rnd_next = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Directed bench for aes_encrypt_ctrl using the FIPS-197 known-answer vectors.
module tb_aes_encrypt_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_IN   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] in;
  logic [127:0] key;
  logic         busy;
  logic [127:0] out;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  aes_encrypt_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in        (in),
    .key       (key),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Present a block at the current low phase; returns at the negedge after acceptance.
  task automatic accept(input logic [127:0] k, input logic [127:0] p);
    in    = p;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    in    = C1_IN;
    key   = C1_KEY;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (out !== 128'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    // First edge with reset low and start high must accept.
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL first_start_busy got=%b exp=1", busy); end
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out !== C1_OUT) begin
      bad++; $display("FAIL first_start_out valid=%b got=%h exp=%h", out_valid, out, C1_OUT);
    end
    @(negedge clk);
  endtask

  task automatic test_c1_latency();
    logic ok;
    accept(C1_KEY, C1_IN);
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (busy !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL c1_busy_window got=0 exp=1"); end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL c1_latency valid=%b exp=1", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL c1_busy_done got=%b exp=0", busy); end
    total++;
    if (out !== C1_OUT) begin bad++; $display("FAIL c1_out got=%h exp=%h", out, C1_OUT); end
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out !== C1_OUT || busy !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL c1_hold got=%h valid=%b exp=%h", out, out_valid, C1_OUT); end
  endtask

  task automatic test_input_hold();
    accept(B_KEY, B_IN);
    for (int k = 0; k < 10; k++) begin
      in  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || out !== B_OUT) begin
      bad++; $display("FAIL input_hold valid=%b got=%h exp=%h", out_valid, out, B_OUT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic ok;
    accept(C1_KEY, C1_IN);
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out !== C1_OUT || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_first valid=%b busy=%b got=%h exp=%h", out_valid, busy, out, C1_OUT);
    end
    accept(B_KEY, B_IN);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_reaccept busy=%b valid=%b exp busy=1 valid=0", busy, out_valid);
    end
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_gap got=0 exp=1"); end
    total++;
    if (out_valid !== 1'b1 || out !== B_OUT) begin
      bad++; $display("FAIL b2b_second valid=%b got=%h exp=%h", out_valid, out, B_OUT);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_reject();
    logic ok;
    accept(C1_KEY, C1_IN);
    repeat (4) @(negedge clk);
    in    = B_IN;
    key   = B_KEY;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out !== C1_OUT) begin
      bad++; $display("FAIL reject_out valid=%b got=%h exp=%h", out_valid, out, C1_OUT);
    end
    ok = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reject_no_extra got=0 exp=1"); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    accept(C1_KEY, C1_IN);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || out !== 128'h0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid busy=%b valid=%b got=%h exp=0", busy, out_valid, out);
    end
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 128'h0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_quiet got=0 exp=1"); end
    accept(C1_KEY, C1_IN);
    repeat (10) @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out !== C1_OUT) begin
      bad++; $display("FAIL reset_mid_rerun valid=%b got=%h exp=%h", out_valid, out, C1_OUT);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in    = '0;
    key   = '0;
    test_reset();
    test_c1_latency();
    test_input_hold();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_ctrl.md
AES_ENCRYPT_CTRL -- requirements
Module: aes_encrypt_ctrl

Interface
REQ-001 Parameter: NR, 10, number of cipher rounds; only 10 (AES-128) is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to encrypt in with key; sampled only when busy=0.
REQ-005 in  input  128  plaintext block; bits [127:120] = FIPS-197 byte 0.
REQ-006 key  input  128  cipher key, same byte ordering as in.
REQ-007 busy  output  1  high while a block is in progress; start ignored while high.
REQ-008 out  output  128  ciphertext; holds last completed result.
REQ-009 out_valid  output  1  one-cycle pulse marking a new value on out.

Function
REQ-010 The block SHALL be an iterative AES-128 encryptor: one state register, one round key register, one 4-bit round counter, one round datapath reused 10 times.
REQ-011 States SHALL be IDLE and BUSY only.
REQ-012 IDLE: on edge with start=1 -> state_reg = in XOR key, rk_reg = key, rnd = 1, busy = 1, go BUSY; start=0 -> remain IDLE.
REQ-013 in and key SHALL be sampled only on the accepting edge; later changes have no effect on the block in flight.
REQ-014 BUSY, rnd 1..9: each edge SHALL compute next_rk = KeyExpand(rk_reg, Rcon[rnd]) combinationally and load state_reg = AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), next_rk), rk_reg = next_rk, rnd = rnd+1.
REQ-015 BUSY, rnd = 10: final round SHALL omit MixColumns; result loads out, out_valid = 1, busy = 0, rnd = 0, go IDLE.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), applied to the most significant byte of the rotated, substituted last word.
REQ-017 KeyExpand SHALL follow FIPS-197: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2' (w0 = bits [127:96]).
REQ-018 Latency: start accepted at edge E0 -> out_valid high in the cycle following edge E0+10 (11 edges inclusive); busy high from after E0 through the cycle before out_valid.
REQ-019 Throughput: start presented in the out_valid cycle (busy=0) SHALL be accepted; back-to-back blocks complete every 11 cycles.
REQ-020 start while busy=1 SHALL be ignored and not queued.
REQ-021 out_valid SHALL be high for exactly one cycle per completed block; out SHALL remain stable until the next completion.
REQ-022 rnd SHALL never exceed 10; values 11-15 unreachable; any illegal state SHALL return to IDLE on the next edge.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, busy=0, out_valid=0, out=128'h0, state_reg=0, rk_reg=0, rnd=0; reset takes priority over start.
REQ-024 reset during BUSY SHALL abort the block with no out_valid pulse; out SHALL read 0 afterwards.
REQ-025 First start after reset deasserts SHALL be accepted on the first edge with reset=0.

Verification
REQ-026 FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, in=00112233445566778899aabbccddeeff, start 1 cycle -> out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid pulse exactly 11 edges after acceptance.
REQ-027 FIPS-197 B: key=2b7e151628aed2a6abf7158809cf4f3c, in=3243f6a8885a308d313198a2e0370734 -> out=3925841d02dc09fbdc118597196a0b32.
REQ-028 Back-to-back: C.1 vector then B vector with start asserted in the out_valid cycle -> both correct results, out_valid pulses 11 cycles apart, busy low for exactly that one cycle.
REQ-029 Busy rejection: start pulsed with a different in/key at rnd=5 -> C.1 result unchanged, no extra out_valid.
REQ-030 Reset mid-op: reset at rnd=6 for 1 cycle -> busy=0, out=0, no out_valid; subsequent C.1 run gives correct result.
REQ-031 Input hold: in/key changed every cycle after acceptance -> result matches values sampled at accept edge.
